grid_streamer: RTL

GRID_STREAMER -- requirements
Module: grid_streamer

---
 rtl/tetris_pkg.sv | 19 +
 rtl/cell_cursor.sv | 68 ++++++
 rtl/grid_streamer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared Tetris playfield dimensions and cell colour codes.
// Imported by the game FSM and the display-side streamer.
package tetris_pkg;

  localparam int ROWS = 22;
  localparam int COLS = 10;
  localparam int CW   = 3;

  typedef enum logic [CW-1:0] {
    CL0, CL1, CL2, CL3, CL4, CL5, CL6, CL7
  } color_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } gs_state_e;

endpackage

// File: rtl/cell_cursor.sv
// Row/column cursor for the grid streamer.
// Exposes next-state indices so the caller can prefetch the cell.
module cell_cursor #(
  parameter int ROWS      = 22,
  parameter int COLS      = 10,
  parameter int SKIP_ROWS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic       adv,
  output logic [4:0] row,
  output logic [3:0] col,
  output logic [4:0] row_nx,
  output logic [3:0] col_nx,
  output logic       last
);

  localparam logic [4:0] R_FIRST = 5'(SKIP_ROWS);
  localparam logic [4:0] R_LAST  = 5'(ROWS - 1);
  localparam logic [3:0] C_LAST  = 4'(COLS - 1);

  logic at_last_nx;

  always_comb begin
    row_nx = row;
    col_nx = col;
    unique case (1'b1)
      clr: begin
        row_nx = '0;
        col_nx = '0;
      end
      load: begin
        row_nx = R_FIRST;
        col_nx = '0;
      end
      adv: begin
        if (col == C_LAST) begin
          col_nx = '0;
          row_nx = row + 5'd1;
        end else begin
          col_nx = col + 4'd1;
        end
      end
      default: ;
    endcase
  end

  assign at_last_nx = (row_nx == R_LAST) &&
                      (col_nx == C_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row  <= '0;
      col  <= '0;
      last <= 1'b0;
    end else begin
      row <= row_nx;
      col <= col_nx;
      if (clr)
        last <= 1'b0;
      else if (load || adv)
        last <= at_last_nx;
    end
  end

endmodule

// File: rtl/grid_streamer.sv
// Snapshots the playfield on start and streams the visible
// cells row-major over a valid/ready link.
module grid_streamer import tetris_pkg::*; #(
  parameter int ROWS      = tetris_pkg::ROWS,
  parameter int COLS      = tetris_pkg::COLS,
  parameter int CW        = tetris_pkg::CW,
  parameter int SKIP_ROWS = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [ROWS-1:0][COLS-1:0][CW-1:0]  grid,
  input  logic                               start,
  input  logic                               ready,
  output logic                               valid,
  output logic [4:0]                         row_o,
  output logic [3:0]                         col_o,
  output logic [CW-1:0]                      color_o,
  output logic                               last,
  output logic                               busy,
  output logic                               done
);

  localparam bit EMPTY = (SKIP_ROWS >= ROWS);
  localparam int RB    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CB    = (COLS > 1) ? $clog2(COLS) : 1;

  gs_state_e state, state_nx;

  logic [ROWS-1:0][COLS-1:0][CW-1:0] snap;
  logic          snap_ld;
  logic          cur_clr;
  logic          cur_load;
  logic          cur_adv;
  logic [4:0]    row_nx;
  logic [3:0]    col_nx;
  logic [CW-1:0] cell_nx;

  cell_cursor #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .SKIP_ROWS (SKIP_ROWS)
  ) u_cursor (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cur_clr),
    .load   (cur_load),
    .adv    (cur_adv),
    .row    (row_o),
    .col    (col_o),
    .row_nx (row_nx),
    .col_nx (col_nx),
    .last   (last)
  );

  always_comb begin
    state_nx = state;
    snap_ld  = 1'b0;
    cur_clr  = 1'b0;
    cur_load = 1'b0;
    cur_adv  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          snap_ld = 1'b1;
          if (EMPTY) begin
            state_nx = DONE;
          end else begin
            state_nx = STREAM;
            cur_load = 1'b1;
          end
        end
      end
      STREAM: begin
        if (valid && ready) begin
          if (last) begin
            state_nx = DONE;
            cur_clr  = 1'b1;
          end else begin
            cur_adv = 1'b1;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Prefetch the next beat's cell; on load the snapshot
  // is not written yet, so read the live grid instead.
  always_comb begin
    cell_nx = '0;
    if (row_nx < 5'(ROWS) && col_nx < 4'(COLS)) begin
      if (snap_ld)
        cell_nx = grid[row_nx[RB-1:0]][col_nx[CB-1:0]];
      else
        cell_nx = snap[row_nx[RB-1:0]][col_nx[CB-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      snap    <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      color_o <= '0;
    end else begin
      state <= state_nx;
      valid <= (state_nx == STREAM);
      busy  <= (state_nx != IDLE);
      done  <= (state_nx == DONE);
      if (snap_ld)
        snap <= grid;
      if (cur_load || cur_adv)
        color_o <= cell_nx;
      else if (cur_clr)
        color_o <= '0;
    end
  end

endmodule
